// File: rtl/k6502_core.sv
// Compact 6502-subset CPU: one bus cycle per clock, multiplexed 8-bit data bus,
// debug taps for architectural state. Unsupported opcodes park the core in HALT.
module k6502_core (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] a,
    inout  wire  [7:0]  d,
    output logic        rw,
    output logic        sync,
    output logic [15:0] debug_pc,
    output logic [7:0]  debug_ir,
    output logic [7:0]  debug_sr,
    output logic [7:0]  debug_ra_data,
    output logic [7:0]  debug_rx_data,
    output logic [7:0]  debug_ry_data,
    output logic [15:0] debug_dl,
    output logic [2:0]  debug_x,
    output logic        debug_ex
);

    typedef enum logic [2:0] {
        ST_RST_LO = 3'd0,
        ST_RST_HI = 3'd1,
        ST_FETCH  = 3'd2,
        ST_OP1    = 3'd3,
        ST_OP2    = 3'd4,
        ST_MEM    = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CL_BAD  = 3'd0,
        CL_IMM  = 3'd1,
        CL_LD   = 3'd2,
        CL_ST   = 3'd3,
        CL_JMP  = 3'd4,
        CL_IMPL = 3'd5,
        CL_BR   = 3'd6
    } op_class_t;

    function automatic op_class_t decode_f(input logic [7:0] op);
        case (op)
            8'hA9, 8'hA2, 8'hA0, 8'h69, 8'hE9,
            8'h29, 8'h09, 8'h49, 8'hC9:          decode_f = CL_IMM;
            8'hAD, 8'hAE, 8'hAC:                 decode_f = CL_LD;
            8'h8D, 8'h8E, 8'h8C:                 decode_f = CL_ST;
            8'h4C:                               decode_f = CL_JMP;
            8'hE8, 8'hC8, 8'hCA, 8'h88, 8'hAA, 8'h8A,
            8'hA8, 8'h98, 8'h18, 8'h38, 8'hEA:   decode_f = CL_IMPL;
            8'h10, 8'h30, 8'h90, 8'hB0, 8'hD0, 8'hF0: decode_f = CL_BR;
            default:                             decode_f = CL_BAD;
        endcase
    endfunction

    // Replace N and Z in a status byte from a result value.
    function automatic logic [7:0] set_nz_f(input logic [7:0] sr, input logic [7:0] v);
        set_nz_f = {v[7], sr[6:2], (v == 8'h00), sr[0]};
    endfunction

    // Binary add with carry-in; returns {V, C, sum}.
    function automatic logic [9:0] add_f(input logic [7:0] x, input logic [7:0] m, input logic cin);
        logic [8:0] s;
        s = {1'b0, x} + {1'b0, m} + {8'h00, cin};
        add_f = {(~(x[7] ^ m[7])) & (x[7] ^ s[7]), s[8], s[7:0]};
    endfunction

    state_t      state_r, nxt_state_s;
    logic [15:0] a_r, nxt_a_s, pc_r, nxt_pc_s, dl_r, nxt_dl_s, pc_inc_s;
    logic        rw_r, nxt_rw_s, sync_r, nxt_sync_s, ex_r, nxt_ex_s, taken_s;
    logic [7:0]  dout_r, nxt_dout_s, ir_r, nxt_ir_s, sr_r, nxt_sr_s;
    logic [7:0]  ra_r, nxt_ra_s, rx_r, nxt_rx_s, ry_r, nxt_ry_s, tmp_s;
    logic [9:0]  alu_s;
    logic [8:0]  cmp_s;
    op_class_t   cls_s, fetch_cls_s;

    assign d             = rw_r ? dout_r : 8'hzz;
    assign a             = a_r;
    assign rw            = rw_r;
    assign sync          = sync_r;
    assign debug_pc      = pc_r;
    assign debug_ir      = ir_r;
    assign debug_sr      = sr_r;
    assign debug_ra_data = ra_r;
    assign debug_rx_data = rx_r;
    assign debug_ry_data = ry_r;
    assign debug_dl      = dl_r;
    assign debug_x       = state_r;
    assign debug_ex      = ex_r;

    // Architectural and bus registers; reset parks the bus on the low vector byte.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r <= ST_RST_LO;
            a_r     <= 16'hFFFC;
            rw_r    <= 1'b0;
            sync_r  <= 1'b0;
            dout_r  <= 8'h00;
            pc_r    <= 16'h0000;
            ir_r    <= 8'hEA;
            ra_r    <= 8'h00;
            rx_r    <= 8'h00;
            ry_r    <= 8'h00;
            sr_r    <= 8'h24;
            dl_r    <= 16'h0000;
            ex_r    <= 1'b0;
        end else begin
            state_r <= nxt_state_s;
            a_r     <= nxt_a_s;
            rw_r    <= nxt_rw_s;
            sync_r  <= nxt_sync_s;
            dout_r  <= nxt_dout_s;
            pc_r    <= nxt_pc_s;
            ir_r    <= nxt_ir_s;
            ra_r    <= nxt_ra_s;
            rx_r    <= nxt_rx_s;
            ry_r    <= nxt_ry_s;
            sr_r    <= nxt_sr_s;
            dl_r    <= nxt_dl_s;
            ex_r    <= nxt_ex_s;
        end
    end

    // Next-state, next-bus-cycle and datapath results for the cycle now ending.
    always_comb begin
        nxt_state_s = state_r;
        nxt_a_s     = a_r;
        nxt_rw_s    = 1'b0;
        nxt_sync_s  = 1'b0;
        nxt_dout_s  = dout_r;
        nxt_pc_s    = pc_r;
        nxt_ir_s    = ir_r;
        nxt_ra_s    = ra_r;
        nxt_rx_s    = rx_r;
        nxt_ry_s    = ry_r;
        nxt_sr_s    = sr_r;
        nxt_dl_s    = dl_r;
        nxt_ex_s    = ex_r;
        pc_inc_s    = pc_r + 16'd1;
        cls_s       = decode_f(ir_r);
        fetch_cls_s = decode_f(d);
        alu_s       = 10'h000;
        cmp_s       = 9'h000;
        tmp_s       = 8'h00;

        case (ir_r)
            8'h10:   taken_s = ~sr_r[7];
            8'h30:   taken_s = sr_r[7];
            8'h90:   taken_s = ~sr_r[0];
            8'hB0:   taken_s = sr_r[0];
            8'hD0:   taken_s = ~sr_r[1];
            8'hF0:   taken_s = sr_r[1];
            default: taken_s = 1'b0;
        endcase

        // Operand-consuming ops: immediates at the end of OP1, absolute loads at the end of MEM.
        if ((state_r == ST_OP1 && cls_s == CL_IMM) || (state_r == ST_MEM && cls_s == CL_LD)) begin
            case (ir_r)
                8'hA9, 8'hAD: begin nxt_ra_s = d; nxt_sr_s = set_nz_f(sr_r, d); end
                8'hA2, 8'hAE: begin nxt_rx_s = d; nxt_sr_s = set_nz_f(sr_r, d); end
                8'hA0, 8'hAC: begin nxt_ry_s = d; nxt_sr_s = set_nz_f(sr_r, d); end
                8'h69, 8'hE9: begin
                    alu_s    = add_f(ra_r, (ir_r == 8'hE9) ? ~d : d, sr_r[0]);
                    nxt_ra_s = alu_s[7:0];
                    nxt_sr_s = set_nz_f(sr_r, alu_s[7:0]);
                    nxt_sr_s[0] = alu_s[8];
                    nxt_sr_s[6] = alu_s[9];
                end
                8'h29, 8'h09, 8'h49: begin
                    tmp_s    = (ir_r == 8'h29) ? (ra_r & d) : (ir_r == 8'h09) ? (ra_r | d) : (ra_r ^ d);
                    nxt_ra_s = tmp_s;
                    nxt_sr_s = set_nz_f(sr_r, tmp_s);
                end
                8'hC9: begin
                    cmp_s    = {1'b0, ra_r} - {1'b0, d};
                    nxt_sr_s = set_nz_f(sr_r, cmp_s[7:0]);
                    nxt_sr_s[0] = ~cmp_s[8];
                end
                default: nxt_sr_s = sr_r;
            endcase
        end else begin
            alu_s = 10'h000;
        end

        case (state_r)
            ST_RST_LO: begin
                nxt_pc_s    = {pc_r[15:8], d};
                nxt_a_s     = 16'hFFFD;
                nxt_state_s = ST_RST_HI;
            end
            ST_RST_HI: begin
                nxt_pc_s    = {d, pc_r[7:0]};
                nxt_a_s     = {d, pc_r[7:0]};
                nxt_sync_s  = 1'b1;
                nxt_state_s = ST_FETCH;
            end
            ST_FETCH: begin
                nxt_ir_s = d;
                nxt_pc_s = pc_inc_s;
                nxt_a_s  = pc_inc_s;
                if (fetch_cls_s == CL_BAD) begin
                    nxt_ex_s    = 1'b1;
                    nxt_state_s = ST_HALT;
                end else begin
                    nxt_state_s = ST_OP1;
                end
            end
            ST_OP1: begin
                case (cls_s)
                    CL_IMM: begin
                        nxt_pc_s    = pc_inc_s;
                        nxt_a_s     = pc_inc_s;
                        nxt_sync_s  = 1'b1;
                        nxt_state_s = ST_FETCH;
                    end
                    CL_LD, CL_ST, CL_JMP: begin
                        nxt_dl_s    = {dl_r[15:8], d};
                        nxt_pc_s    = pc_inc_s;
                        nxt_a_s     = pc_inc_s;
                        nxt_state_s = ST_OP2;
                    end
                    CL_IMPL: begin
                        case (ir_r)
                            8'hE8: begin nxt_rx_s = rx_r + 8'd1; nxt_sr_s = set_nz_f(sr_r, rx_r + 8'd1); end
                            8'hC8: begin nxt_ry_s = ry_r + 8'd1; nxt_sr_s = set_nz_f(sr_r, ry_r + 8'd1); end
                            8'hCA: begin nxt_rx_s = rx_r - 8'd1; nxt_sr_s = set_nz_f(sr_r, rx_r - 8'd1); end
                            8'h88: begin nxt_ry_s = ry_r - 8'd1; nxt_sr_s = set_nz_f(sr_r, ry_r - 8'd1); end
                            8'hAA: begin nxt_rx_s = ra_r; nxt_sr_s = set_nz_f(sr_r, ra_r); end
                            8'h8A: begin nxt_ra_s = rx_r; nxt_sr_s = set_nz_f(sr_r, rx_r); end
                            8'hA8: begin nxt_ry_s = ra_r; nxt_sr_s = set_nz_f(sr_r, ra_r); end
                            8'h98: begin nxt_ra_s = ry_r; nxt_sr_s = set_nz_f(sr_r, ry_r); end
                            8'h18: nxt_sr_s = {sr_r[7:1], 1'b0};
                            8'h38: nxt_sr_s = {sr_r[7:1], 1'b1};
                            default: nxt_sr_s = sr_r;
                        endcase
                        nxt_a_s     = pc_r;
                        nxt_sync_s  = 1'b1;
                        nxt_state_s = ST_FETCH;
                    end
                    CL_BR: begin
                        nxt_pc_s = pc_inc_s;
                        nxt_a_s  = pc_inc_s;
                        if (taken_s) begin
                            // Target parked in DL; the extra cycle re-reads the old PC.
                            nxt_dl_s    = pc_inc_s + {{8{d[7]}}, d};
                            nxt_state_s = ST_OP2;
                        end else begin
                            nxt_sync_s  = 1'b1;
                            nxt_state_s = ST_FETCH;
                        end
                    end
                    default: begin
                        nxt_ex_s    = 1'b1;
                        nxt_a_s     = pc_r;
                        nxt_state_s = ST_HALT;
                    end
                endcase
            end
            ST_OP2: begin
                case (cls_s)
                    CL_JMP: begin
                        nxt_dl_s    = {d, dl_r[7:0]};
                        nxt_pc_s    = {d, dl_r[7:0]};
                        nxt_a_s     = {d, dl_r[7:0]};
                        nxt_sync_s  = 1'b1;
                        nxt_state_s = ST_FETCH;
                    end
                    CL_LD, CL_ST: begin
                        nxt_dl_s    = {d, dl_r[7:0]};
                        nxt_pc_s    = pc_inc_s;
                        nxt_a_s     = {d, dl_r[7:0]};
                        nxt_rw_s    = (cls_s == CL_ST);
                        nxt_dout_s  = (ir_r == 8'h8E) ? rx_r : (ir_r == 8'h8C) ? ry_r : ra_r;
                        nxt_state_s = ST_MEM;
                    end
                    CL_BR: begin
                        nxt_pc_s    = dl_r;
                        nxt_a_s     = dl_r;
                        nxt_sync_s  = 1'b1;
                        nxt_state_s = ST_FETCH;
                    end
                    default: begin
                        nxt_ex_s    = 1'b1;
                        nxt_a_s     = pc_r;
                        nxt_state_s = ST_HALT;
                    end
                endcase
            end
            ST_MEM: begin
                nxt_a_s     = pc_r;
                nxt_sync_s  = 1'b1;
                nxt_state_s = ST_FETCH;
            end
            ST_HALT: begin
                nxt_a_s     = pc_r;
                nxt_state_s = ST_HALT;
            end
            default: begin
                nxt_a_s     = 16'hFFFC;
                nxt_state_s = ST_RST_LO;
            end
        endcase
    end

endmodule

// File: tb/tb_k6502_core.sv
// Scoreboard bench for k6502_core: a program in a modelled ROM, expected fetch
// and write traces queued up front, a negedge monitor popping and comparing them.
module tb_k6502_core;

    logic        clk = 1'b0;
    logic        rst_n;
    wire  [15:0] a;
    wire  [7:0]  d;
    wire         rw, sync, debug_ex;
    wire  [15:0] debug_pc, debug_dl;
    wire  [7:0]  debug_ir, debug_sr, debug_ra_data, debug_rx_data, debug_ry_data;
    wire  [2:0]  debug_x;

    logic [7:0] rom [0:32767];
    wire        rom_oe_n = rw | ~a[15];
    assign d = rom_oe_n ? 8'hzz : rom[a[14:0]];

    k6502_core dut (
        .clk(clk), .rst_n(rst_n), .a(a), .d(d), .rw(rw), .sync(sync),
        .debug_pc(debug_pc), .debug_ir(debug_ir), .debug_sr(debug_sr),
        .debug_ra_data(debug_ra_data), .debug_rx_data(debug_rx_data),
        .debug_ry_data(debug_ry_data), .debug_dl(debug_dl),
        .debug_x(debug_x), .debug_ex(debug_ex)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  ra, rx, ry, sr, delta;
    } fetch_t;
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data, cyc;
    } write_t;

    fetch_t fq[$];
    write_t wq[$];
    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int last_sync  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input logic [15:0] addr, input logic [7:0] v);
        rom[addr[14:0]] = v;
    endtask

    task automatic ef(input logic [15:0] addr, input logic [7:0] ra, input logic [7:0] rx,
                      input logic [7:0] ry, input logic [7:0] sr, input logic [7:0] delta);
        fq.push_back({addr, ra, rx, ry, sr, delta});
    endtask

    // Monitor: every sync cycle and every write cycle is matched against the queues.
    always @(negedge clk) begin
        fetch_t f;
        write_t w;
        if (rst_n) begin
            cyc       = 0;
            last_sync = 0;
        end else begin
            cyc++;
            if (sync) begin
                if (fq.size() == 0) begin
                    chk("unexpected_fetch", {16'h0000, a}, 32'hFFFF_FFFF);
                end else begin
                    f = fq.pop_front();
                    chk("fetch_addr", {16'h0000, a}, {16'h0000, f.addr});
                    chk("fetch_A", {24'h0, debug_ra_data}, {24'h0, f.ra});
                    chk("fetch_X", {24'h0, debug_rx_data}, {24'h0, f.rx});
                    chk("fetch_Y", {24'h0, debug_ry_data}, {24'h0, f.ry});
                    chk("fetch_SR", {24'h0, debug_sr}, {24'h0, f.sr});
                    chk("fetch_cycles", cyc - last_sync, {24'h0, f.delta});
                end
                last_sync = cyc;
            end
            if (rw) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", {16'h0000, a}, 32'hFFFF_FFFF);
                end else begin
                    w = wq.pop_front();
                    chk("write_addr", {16'h0000, a}, {16'h0000, w.addr});
                    chk("write_data", {24'h0, d}, {24'h0, w.data});
                    chk("write_cycle", cyc, {24'h0, w.cyc});
                end
            end
        end
    end

    task automatic drain;
        for (int i = 0; i < 300 && (fq.size() != 0 || wq.size() != 0); i++) begin
            @(negedge clk);
            #1;
        end
        chk("drain_timeout", fq.size() + wq.size(), 32'd0);
    endtask

    task automatic chk_reset_state;
        chk("rst_a", {16'h0, a}, 32'h0000_FFFC);
        chk("rst_rw", {31'h0, rw}, 32'd0);
        chk("rst_sync", {31'h0, sync}, 32'd0);
        chk("rst_pc", {16'h0, debug_pc}, 32'd0);
        chk("rst_ir", {24'h0, debug_ir}, 32'h0000_00EA);
        chk("rst_sr", {24'h0, debug_sr}, 32'h0000_0024);
        chk("rst_A", {24'h0, debug_ra_data}, 32'd0);
        chk("rst_X", {24'h0, debug_rx_data}, 32'd0);
        chk("rst_Y", {24'h0, debug_ry_data}, 32'd0);
        chk("rst_dl", {16'h0, debug_dl}, 32'd0);
        chk("rst_state", {29'h0, debug_x}, 32'd0);
        chk("rst_ex", {31'h0, debug_ex}, 32'd0);
    endtask

    initial begin
        logic [7:0] prog [0:40];
        prog = '{8'hA9, 8'h5A, 8'h8D, 8'hAD, 8'hDE, 8'h38, 8'hA9, 8'h7F, 8'h69, 8'h00,
                 8'h69, 8'h80, 8'hA2, 8'h03, 8'hCA, 8'hD0, 8'hFD, 8'hA0, 8'hF0, 8'h98,
                 8'hC9, 8'hF0, 8'hE9, 8'h10, 8'h49, 8'hFF, 8'hAE, 8'h00, 8'h80, 8'h8E,
                 8'h34, 8'h12, 8'h18, 8'h90, 8'h05, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02,
                 8'h4C};
        for (int i = 0; i < 32768; i++) rom[i] = 8'h02;
        for (int i = 0; i < 41; i++) put(16'h8000 + 16'(i), prog[i]);
        put(16'h8029, 8'h00);
        put(16'h802A, 8'h90);
        put(16'h9000, 8'h02);
        put(16'hFFFC, 8'h00);
        put(16'hFFFD, 8'h80);

        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state();

        // addr, A, X, Y, SR, cycles since the previous fetch
        ef(16'h8000, 8'h00, 8'h00, 8'h00, 8'h24, 8'd3);
        ef(16'h8002, 8'h5A, 8'h00, 8'h00, 8'h24, 8'd2);
        ef(16'h8005, 8'h5A, 8'h00, 8'h00, 8'h24, 8'd4);
        ef(16'h8006, 8'h5A, 8'h00, 8'h00, 8'h25, 8'd2);
        ef(16'h8008, 8'h7F, 8'h00, 8'h00, 8'h25, 8'd2);
        ef(16'h800A, 8'h80, 8'h00, 8'h00, 8'hE4, 8'd2);
        ef(16'h800C, 8'h00, 8'h00, 8'h00, 8'h67, 8'd2);
        ef(16'h800E, 8'h00, 8'h03, 8'h00, 8'h65, 8'd2);
        ef(16'h800F, 8'h00, 8'h02, 8'h00, 8'h65, 8'd2);
        ef(16'h800E, 8'h00, 8'h02, 8'h00, 8'h65, 8'd3);
        ef(16'h800F, 8'h00, 8'h01, 8'h00, 8'h65, 8'd2);
        ef(16'h800E, 8'h00, 8'h01, 8'h00, 8'h65, 8'd3);
        ef(16'h800F, 8'h00, 8'h00, 8'h00, 8'h67, 8'd2);
        ef(16'h8011, 8'h00, 8'h00, 8'h00, 8'h67, 8'd2);
        ef(16'h8013, 8'h00, 8'h00, 8'hF0, 8'hE5, 8'd2);
        ef(16'h8014, 8'hF0, 8'h00, 8'hF0, 8'hE5, 8'd2);
        ef(16'h8016, 8'hF0, 8'h00, 8'hF0, 8'h67, 8'd2);
        ef(16'h8018, 8'hE0, 8'h00, 8'hF0, 8'hA5, 8'd2);
        ef(16'h801A, 8'h1F, 8'h00, 8'hF0, 8'h25, 8'd2);
        ef(16'h801D, 8'h1F, 8'hA9, 8'hF0, 8'hA5, 8'd4);
        ef(16'h8020, 8'h1F, 8'hA9, 8'hF0, 8'hA5, 8'd4);
        ef(16'h8021, 8'h1F, 8'hA9, 8'hF0, 8'hA4, 8'd2);
        ef(16'h8028, 8'h1F, 8'hA9, 8'hF0, 8'hA4, 8'd3);
        ef(16'h9000, 8'h1F, 8'hA9, 8'hF0, 8'hA4, 8'd3);
        wq.push_back({16'hDEAD, 8'h5A, 8'd8});
        wq.push_back({16'h1234, 8'hA9, 8'd50});

        rst_n = 1'b0;
        drain();

        // First cycle after the illegal fetch: halted, flag raised, no writes.
        @(negedge clk);
        #1;
        chk("halt_ex", {31'h0, debug_ex}, 32'd1);
        chk("halt_state", {29'h0, debug_x}, 32'd6);
        chk("halt_ir", {24'h0, debug_ir}, 32'h0000_0002);
        chk("halt_pc", {16'h0, debug_pc}, 32'h0000_9001);
        chk("halt_rw", {31'h0, rw}, 32'd0);
        chk("halt_dl", {16'h0, debug_dl}, 32'h0000_9000);
        repeat (4) @(negedge clk);
        #1;
        chk("halt_pc_frozen", {16'h0, debug_pc}, 32'h0000_9001);
        chk("halt_a", {16'h0, a}, 32'h0000_9001);
        chk("halt_ex_sticky", {31'h0, debug_ex}, 32'd1);
        chk("halt_rw_idle", {31'h0, rw}, 32'd0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_state();
        ef(16'h8000, 8'h00, 8'h00, 8'h00, 8'h24, 8'd3);
        rst_n = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
